// File: rtl/arith_port_driver_pkg.sv
// arith_port_driver_pkg: adder peripheral port map and per-stage port code lookup
package arith_port_driver_pkg;
  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int PORT_IDLE = 0;
  localparam int PORT_ADDED_DATA = 1;
  localparam int PORT_ADD_DATA = 2;
  localparam int PORT_ADD_RESULT = 3;
  localparam int PORT_ADD_CARRY = 4;
  localparam int PORT_MINUSED_DATA = 5;
  localparam int PORT_MINUS_DATA = 6;
  localparam int PORT_MINUS_RESULT = 7;
  localparam int PORT_MINUS_CARRY = 8;
  typedef enum logic [1:0] {STG_A, STG_B, STG_RES, STG_CARRY} stage_e;
  function automatic int port_code(input logic sub, input stage_e stg);
    return sub ? (stg == STG_A ? PORT_MINUSED_DATA : stg == STG_B ? PORT_MINUS_DATA :
                  stg == STG_RES ? PORT_MINUS_RESULT : PORT_MINUS_CARRY)
               : (stg == STG_A ? PORT_ADDED_DATA : stg == STG_B ? PORT_ADD_DATA :
                  stg == STG_RES ? PORT_ADD_RESULT : PORT_ADD_CARRY);
  endfunction
endpackage

// File: rtl/arith_port_driver.sv
// arith_port_driver: sequences one add/sub command through the adder's port bus and returns sum/carry
module arith_port_driver
  import arith_port_driver_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_cmd_valid,
  output logic                  o_cmd_ready,
  input  logic                  i_cmd_op,
  input  logic [DATA_WIDTH-1:0] i_cmd_a,
  input  logic [DATA_WIDTH-1:0] i_cmd_b,
  output logic                  o_rsp_valid,
  input  logic                  i_rsp_ready,
  output logic [DATA_WIDTH-1:0] o_rsp_data,
  output logic                  o_rsp_carry,
  output logic [DATA_WIDTH-1:0] o_port,
  output logic [DATA_WIDTH-1:0] o_data,
  input  logic [DATA_WIDTH-1:0] i_result
);
  typedef enum logic [2:0] {IDLE, WR_A, WR_B, REQ_RES, REQ_CARRY, CAP_CARRY, RESP} state_e;
  state_e state;
  logic op_q;
  logic [DATA_WIDTH-1:0] b_q;
  assign o_cmd_ready = state == IDLE;
  assign o_rsp_valid = state == RESP;
  // o_port/o_data are loaded with the codes of the state being entered, so they line up with it
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      op_q <= 1'b0;
      b_q <= '0;
      o_rsp_data <= '0;
      o_rsp_carry <= 1'b0;
      o_port <= DATA_WIDTH'(PORT_IDLE);
      o_data <= '0;
    end else begin
      case (state)
        IDLE: if (i_cmd_valid) begin
          state <= WR_A;
          op_q <= i_cmd_op;
          b_q <= i_cmd_b;
          o_port <= DATA_WIDTH'(port_code(i_cmd_op, STG_A));
          o_data <= i_cmd_a;
        end
        WR_A: begin
          state <= WR_B;
          o_port <= DATA_WIDTH'(port_code(op_q, STG_B));
          o_data <= b_q;
        end
        WR_B: begin
          state <= REQ_RES;
          o_port <= DATA_WIDTH'(port_code(op_q, STG_RES));
          o_data <= '0;
        end
        REQ_RES: begin
          state <= REQ_CARRY;
          o_port <= DATA_WIDTH'(port_code(op_q, STG_CARRY));
        end
        REQ_CARRY: begin
          state <= CAP_CARRY;
          o_rsp_data <= i_result;
          o_port <= DATA_WIDTH'(PORT_IDLE);
        end
        CAP_CARRY: begin
          state <= RESP;
          o_rsp_carry <= i_result[0];
        end
        RESP: if (i_rsp_ready) state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_arith_port_driver.sv
// tb_arith_port_driver: directed checks of the driver against a behavioural adder peripheral
module tb_arith_port_driver;
  import arith_port_driver_pkg::*;
  localparam int DW = 16;
  localparam logic [DW-1:0] P_IDLE = DW'(PORT_IDLE);
  localparam logic [DW-1:0] P_ADDED = DW'(PORT_ADDED_DATA);
  localparam logic [DW-1:0] P_ADD = DW'(PORT_ADD_DATA);
  localparam logic [DW-1:0] P_ADD_RES = DW'(PORT_ADD_RESULT);
  localparam logic [DW-1:0] P_ADD_CAR = DW'(PORT_ADD_CARRY);
  localparam logic [DW-1:0] P_MINUSED = DW'(PORT_MINUSED_DATA);
  localparam logic [DW-1:0] P_MINUS = DW'(PORT_MINUS_DATA);
  localparam logic [DW-1:0] P_MIN_RES = DW'(PORT_MINUS_RESULT);
  localparam logic [DW-1:0] P_MIN_CAR = DW'(PORT_MINUS_CARRY);
  logic clk = 1'b0, rst = 1'b1;
  logic i_cmd_valid = 1'b0, i_cmd_op = 1'b0, i_rsp_ready = 1'b1;
  logic [DW-1:0] i_cmd_a = '0, i_cmd_b = '0;
  logic o_cmd_ready, o_rsp_valid, o_rsp_carry;
  logic [DW-1:0] o_rsp_data, o_port, o_data, i_result;
  int vectors = 0, miscompares = 0;
  arith_port_driver #(.DATA_WIDTH(DW)) dut (
    .clk(clk), .rst(rst), .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
    .i_cmd_op(i_cmd_op), .i_cmd_a(i_cmd_a), .i_cmd_b(i_cmd_b), .o_rsp_valid(o_rsp_valid),
    .i_rsp_ready(i_rsp_ready), .o_rsp_data(o_rsp_data), .o_rsp_carry(o_rsp_carry),
    .o_port(o_port), .o_data(o_data), .i_result(i_result)
  );
  always #5 clk = ~clk;
  // behavioural adder peripheral: registered output, 0 on any non-read port
  logic [DW-1:0] ad_a, ad_b, mi_a, mi_b;
  logic [DW:0] add_full, sub_full;
  assign add_full = {1'b0, ad_a} + {1'b0, ad_b};
  assign sub_full = {1'b0, mi_a} + {1'b0, ~mi_b} + 17'd1;
  always @(posedge clk) begin
    if (rst) begin
      ad_a <= '0; ad_b <= '0; mi_a <= '0; mi_b <= '0; i_result <= '0;
    end else begin
      i_result <= '0;
      if (o_port == P_ADDED) ad_a <= o_data;
      if (o_port == P_ADD) ad_b <= o_data;
      if (o_port == P_MINUSED) mi_a <= o_data;
      if (o_port == P_MINUS) mi_b <= o_data;
      if (o_port == P_ADD_RES) i_result <= add_full[DW-1:0];
      if (o_port == P_ADD_CAR) i_result <= {{(DW-1){1'b0}}, add_full[DW]};
      if (o_port == P_MIN_RES) i_result <= sub_full[DW-1:0];
      if (o_port == P_MIN_CAR) i_result <= {{(DW-1){1'b0}}, sub_full[DW]};
    end
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
  // issues one command and records port/data/valid during the six cycles after acceptance
  task automatic run_seq(input logic op, input logic [DW-1:0] a, input logic [DW-1:0] b,
                         output logic [5:0][DW-1:0] p, output logic [5:0][DW-1:0] d,
                         output logic [5:0] rv);
    @(negedge clk);
    vectors++;
    if (o_cmd_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL issue_ready: got %b want 1", o_cmd_ready);
    end
    i_cmd_valid = 1'b1; i_cmd_op = op; i_cmd_a = a; i_cmd_b = b;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      if (i == 0) begin
        i_cmd_valid = 1'b0; i_cmd_op = ~op; i_cmd_a = 16'hdead; i_cmd_b = 16'hbeef;
      end
      p[i] = o_port; d[i] = o_data; rv[i] = o_rsp_valid;
    end
  endtask
  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      vectors++;
      if ({o_port, o_data, o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_carry} !==
          {P_IDLE, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0}) begin
        miscompares++;
        $display("FAIL reset_idle[%0d]: port=%h data=%h rdy=%b rv=%b rd=%h rc=%b want port=%h 0 1 0 0 0",
                 i, o_port, o_data, o_cmd_ready, o_rsp_valid, o_rsp_data, o_rsp_carry, P_IDLE);
      end
    end
  endtask
  task automatic test_cmd(input string name, input logic op, input logic [DW-1:0] a,
                          input logic [DW-1:0] b, input logic [DW-1:0] exp_d, input logic exp_c);
    logic [5:0][DW-1:0] p, d, ep, ed;
    logic [5:0] rv;
    ep = op ? {P_IDLE, P_IDLE, P_MIN_CAR, P_MIN_RES, P_MINUS, P_MINUSED}
            : {P_IDLE, P_IDLE, P_ADD_CAR, P_ADD_RES, P_ADD, P_ADDED};
    ed = {16'h0, 16'h0, 16'h0, 16'h0, b, a};
    run_seq(op, a, b, p, d, rv);
    vectors++;
    if (p !== ep) begin
      miscompares++;
      $display("FAIL %s_ports: got %h want %h", name, p, ep);
    end
    vectors++;
    if (d !== ed) begin
      miscompares++;
      $display("FAIL %s_data: got %h want %h", name, d, ed);
    end
    vectors++;
    if (rv !== 6'b100000) begin
      miscompares++;
      $display("FAIL %s_rsp_timing: got %b want 100000", name, rv);
    end
    vectors++;
    if ({o_rsp_data, o_rsp_carry} !== {exp_d, exp_c}) begin
      miscompares++;
      $display("FAIL %s_result: got %h/%b want %h/%b", name, o_rsp_data, o_rsp_carry, exp_d, exp_c);
    end
    @(negedge clk);
    vectors++;
    if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL %s_return_idle: rv=%b rdy=%b want 0 1", name, o_rsp_valid, o_cmd_ready);
    end
  endtask
  task automatic test_back_to_back();
    logic [5:0][DW-1:0] p, d;
    logic [5:0] rv;
    i_rsp_ready = 1'b0;
    run_seq(1'b0, 16'h0100, 16'h0023, p, d, rv);
    i_cmd_valid = 1'b1; i_cmd_op = 1'b0; i_cmd_a = 16'h1234; i_cmd_b = 16'h1111;
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if ({o_rsp_valid, o_cmd_ready, o_rsp_data, o_rsp_carry, o_port} !== {2'b10, 16'h0123, 1'b0, P_IDLE}) begin
        miscompares++;
        $display("FAIL backpressure[%0d]: rv=%b rdy=%b rd=%h rc=%b port=%h want 1 0 0123 0 %h",
                 i, o_rsp_valid, o_cmd_ready, o_rsp_data, o_rsp_carry, o_port, P_IDLE);
      end
      @(negedge clk);
    end
    i_rsp_ready = 1'b1;
    @(negedge clk);
    vectors++;
    if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin
      miscompares++;
      $display("FAIL b2b_handshake: rv=%b rdy=%b want 0 1", o_rsp_valid, o_cmd_ready);
    end
    @(negedge clk);
    i_cmd_valid = 1'b0;
    vectors++;
    if ({o_port, o_data, o_cmd_ready} !== {P_ADDED, 16'h1234, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_accept: port=%h data=%h rdy=%b want %h 1234 0", o_port, o_data, o_cmd_ready, P_ADDED);
    end
    repeat (5) @(negedge clk);
    vectors++;
    if ({o_rsp_valid, o_rsp_data, o_rsp_carry} !== {1'b1, 16'h2345, 1'b0}) begin
      miscompares++;
      $display("FAIL b2b_result: rv=%b rd=%h rc=%b want 1 2345 0", o_rsp_valid, o_rsp_data, o_rsp_carry);
    end
    @(negedge clk);
  endtask
  task automatic test_reset_mid();
    @(negedge clk);
    i_cmd_valid = 1'b1; i_cmd_op = 1'b0; i_cmd_a = 16'h0007; i_cmd_b = 16'h0009;
    @(negedge clk);
    i_cmd_valid = 1'b0;
    repeat (2) @(negedge clk);
    vectors++;
    if (o_port !== P_ADD_RES) begin
      miscompares++;
      $display("FAIL mid_req_res: port=%h want %h", o_port, P_ADD_RES);
    end
    rst = 1'b1;
    i_cmd_valid = 1'b1;
    @(negedge clk);
    vectors++;
    if ({o_port, o_data, o_cmd_ready, o_rsp_valid, o_rsp_data} !== {P_IDLE, 16'h0, 2'b10, 16'h0}) begin
      miscompares++;
      $display("FAIL mid_reset: port=%h data=%h rdy=%b rv=%b rd=%h want %h 0 1 0 0",
               o_port, o_data, o_cmd_ready, o_rsp_valid, o_rsp_data, P_IDLE);
    end
    @(negedge clk);
    vectors++;
    if (o_port !== P_IDLE) begin
      miscompares++;
      $display("FAIL valid_in_reset: port=%h want %h", o_port, P_IDLE);
    end
    i_cmd_valid = 1'b0;
    rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      vectors++;
      if ({o_rsp_valid, o_cmd_ready} !== 2'b01) begin
        miscompares++;
        $display("FAIL post_reset_quiet[%0d]: rv=%b rdy=%b want 0 1", i, o_rsp_valid, o_cmd_ready);
      end
    end
    test_cmd("add_after_reset", 1'b0, 16'h0002, 16'h0002, 16'h0004, 1'b0);
  endtask
  initial begin
    test_reset();
    test_cmd("add_5_3", 1'b0, 16'h0005, 16'h0003, 16'h0008, 1'b0);
    test_cmd("add_wrap", 1'b0, 16'hFFFF, 16'h0001, 16'h0000, 1'b1);
    test_cmd("sub_5_3", 1'b1, 16'h0005, 16'h0003, 16'h0002, 1'b1);
    test_cmd("sub_3_5", 1'b1, 16'h0003, 16'h0005, 16'hFFFE, 1'b0);
    test_cmd("sub_equal", 1'b1, 16'h8000, 16'h8000, 16'h0000, 1'b1);
    test_back_to_back();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
